// File: rtl/burst_regfile.sv
// burst_regfile
//   Single-port, byte-masked register-file memory with an AXI4-style burst
//   address generator (FIXED / INCR / WRAP inside a 2^OFT_WIDTH-byte page).
//   The protocol FSM above this block only issues start/beat strobes.
//
//   Build option: define SRAM_WRAP_EN to enable WRAP bursts. Without it,
//   burst type 10 steps like INCR.
//
//   Ports
//     aclk, aresetn          clock, async active-low reset
//     start_i                load descriptor (addr_i, len_i, size_i, burst_i)
//     beat_i, wen_i          one access per beat; write when wen_i=1
//     wstrb_i, wdata_i       byte enables and write data
//     rdata_o, rvalid_o      registered read data, valid one cycle after beat
//     addr_o, last_o, busy_o current beat address, final-beat flag, active
//
//   state    | meaning
//   ST_IDLE  | no burst loaded; beats are ignored
//   ST_BURST | burst active; each beat accesses addr_o and advances
module burst_regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_DEPTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int OFT_WIDTH  = 12
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [7:0]              len_i,
  input  logic [2:0]              size_i,
  input  logic [1:0]              burst_i,
  input  logic                    beat_i,
  input  logic                    wen_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    last_o,
  output logic                    busy_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(NB);
  localparam int IDXW  = $clog2(WORD_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0]   mem_q [WORD_DEPTH];

  logic                    access;
  logic                    en_n, wen_n;
  logic [NB-1:0]           bm_n;
  logic [IDXW-1:0]         word_idx;
  logic [2:0]              size_clamp;
  logic [OFT_WIDTH-1:0]    off, b_bytes, incr_off, next_off;
  logic                    use_fixed, use_wrap;
`ifdef SRAM_WRAP_EN
  logic [OFT_WIDTH-1:0]    w_bytes, wrap_off;
`endif

  assign busy_o   = (state_q == ST_BURST);
  assign last_o   = busy_o && (cnt_q == len_q);
  assign addr_o   = addr_q;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign word_idx = addr_q[LOG2B +: IDXW];

  // start_i wins over a coincident beat, so the beat must not reach the array.
  assign access = beat_i & busy_o & ~start_i;
  assign en_n   = ~access;
  assign wen_n  = ~(access & wen_i);
  assign bm_n   = ~wstrb_i;

  assign size_clamp = (size_i > 3'(LOG2B)) ? 3'(LOG2B) : size_i;

  always_comb begin
    off      = addr_q[OFT_WIDTH-1:0];
    b_bytes  = OFT_WIDTH'(1) << size_q;
    incr_off = (off & ~(b_bytes - OFT_WIDTH'(1))) + b_bytes;
    // Reserved type 11 steps like FIXED.
    use_fixed = (burst_q == 2'b00) || (burst_q == 2'b11);
    use_wrap  = 1'b0;
`ifdef SRAM_WRAP_EN
    w_bytes = b_bytes;
    case (len_q)
      8'd1:    begin use_wrap = (burst_q == 2'b10); w_bytes = b_bytes << 1; end
      8'd3:    begin use_wrap = (burst_q == 2'b10); w_bytes = b_bytes << 2; end
      8'd7:    begin use_wrap = (burst_q == 2'b10); w_bytes = b_bytes << 3; end
      8'd15:   begin use_wrap = (burst_q == 2'b10); w_bytes = b_bytes << 4; end
      default: use_wrap = 1'b0;
    endcase
    wrap_off = (off & ~(w_bytes - OFT_WIDTH'(1))) |
               ((off + b_bytes) & (w_bytes - OFT_WIDTH'(1)));
`endif
    if (use_fixed) begin
      next_off = off;
    end else if (use_wrap) begin
`ifdef SRAM_WRAP_EN
      next_off = wrap_off;
`else
      next_off = incr_off;
`endif
    end else begin
      next_off = incr_off;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (start_i) begin
      state_d = ST_BURST;
      addr_d  = addr_i;
      cnt_d   = 8'd0;
      len_d   = len_i;
      size_d  = size_clamp;
      burst_d = burst_i;
    end else if (access) begin
      if (!wen_i) begin
        rdata_d  = mem_q[word_idx];
        rvalid_d = 1'b1;
      end
      addr_d = {addr_q[ADDR_WIDTH-1:OFT_WIDTH], next_off};
      if (last_o) begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately not reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (!en_n && !wen_n) begin
      for (int b = 0; b < NB; b++) begin
        if (!bm_n[b]) mem_q[word_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_burst_regfile.sv
module tb_burst_regfile;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start_i;
  logic [31:0] addr_i;
  logic [7:0]  len_i;
  logic [2:0]  size_i;
  logic [1:0]  burst_i;
  logic        beat_i;
  logic        wen_i;
  logic [7:0]  wstrb_i;
  logic [63:0] wdata_i;
  logic [63:0] rdata_o;
  logic        rvalid_o;
  logic [31:0] addr_o;
  logic        last_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  burst_regfile dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .start_i  (start_i),
    .addr_i   (addr_i),
    .len_i    (len_i),
    .size_i   (size_i),
    .burst_i  (burst_i),
    .beat_i   (beat_i),
    .wen_i    (wen_i),
    .wstrb_i  (wstrb_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .addr_o   (addr_o),
    .last_o   (last_o),
    .busy_o   (busy_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    start_i = 1'b1; beat_i = 1'b0;
    addr_i = a; len_i = l; size_i = s; burst_i = b;
    tick();
    start_i = 1'b0;
  endtask

  function automatic logic [63:0] pat(input int k);
    return 64'h1111_1111_1111_1111 * 64'(k);
  endfunction

  logic [31:0] wrap_exp [4];

  initial begin
    aresetn = 1'b0; start_i = 1'b0; addr_i = '0; len_i = '0; size_i = '0;
    burst_i = '0; beat_i = 1'b0; wen_i = 1'b0; wstrb_i = '0; wdata_i = '0;
    #12;
    chk("rst_busy",   64'(busy_o),   64'd0);
    chk("rst_addr",   64'(addr_o),   64'd0);
    chk("rst_last",   64'(last_o),   64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_rdata",  rdata_o,       64'd0);
    aresetn = 1'b1;
    tick();

    // Fill words 0..3 with an INCR write burst.
    do_start(32'h0, 8'd3, 3'd3, 2'b01);
    chk("wr_start_busy", 64'(busy_o), 64'd1);
    for (int k = 0; k < 4; k++) begin
      beat_i = 1'b1; wen_i = 1'b1; wstrb_i = 8'hFF; wdata_i = pat(k);
      chk($sformatf("wr_addr%0d", k), 64'(addr_o), 64'(8 * k));
      tick();
    end
    beat_i = 1'b0; wen_i = 1'b0;
    chk("wr_done_busy", 64'(busy_o), 64'd0);
    chk("wr_no_rvalid", 64'(rvalid_o), 64'd0);

    // INCR read, back-to-back beats.
    do_start(32'h0, 8'd3, 3'd3, 2'b01);
    for (int k = 0; k < 4; k++) begin
      beat_i = 1'b1; wen_i = 1'b0;
      chk($sformatf("rd_addr%0d", k), 64'(addr_o), 64'(8 * k));
      chk($sformatf("rd_last%0d", k), 64'(last_o), 64'(k == 3));
      tick();
      chk($sformatf("rd_rvalid%0d", k), 64'(rvalid_o), 64'd1);
      chk($sformatf("rd_data%0d", k), rdata_o, pat(k));
    end
    beat_i = 1'b0;
    chk("rd_done_busy", 64'(busy_o), 64'd0);
    tick();
    chk("rd_rvalid_drop", 64'(rvalid_o), 64'd0);
    chk("rd_data_hold", rdata_o, pat(3));

    // WRAP burst.
`ifdef SRAM_WRAP_EN
    wrap_exp[0] = 32'h18; wrap_exp[1] = 32'h00; wrap_exp[2] = 32'h08; wrap_exp[3] = 32'h10;
`else
    wrap_exp[0] = 32'h18; wrap_exp[1] = 32'h20; wrap_exp[2] = 32'h28; wrap_exp[3] = 32'h30;
`endif
    do_start(32'h18, 8'd3, 3'd3, 2'b10);
    for (int k = 0; k < 4; k++) begin
      beat_i = 1'b1; wen_i = 1'b0;
      chk($sformatf("wrap_addr%0d", k), 64'(addr_o), 64'(wrap_exp[k]));
      tick();
    end
    beat_i = 1'b0;

    // FIXED burst.
    do_start(32'h20, 8'd2, 3'd3, 2'b00);
    for (int k = 0; k < 3; k++) begin
      beat_i = 1'b1; wen_i = 1'b0;
      chk($sformatf("fix_addr%0d", k), 64'(addr_o), 64'h20);
      chk($sformatf("fix_last%0d", k), 64'(last_o), 64'(k == 2));
      tick();
    end
    beat_i = 1'b0;
    chk("fix_done_busy", 64'(busy_o), 64'd0);

    // Byte mask on word at 0x40.
    do_start(32'h40, 8'd1, 3'd3, 2'b00);
    beat_i = 1'b1; wen_i = 1'b1; wstrb_i = 8'hFF; wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    wstrb_i = 8'h0F; wdata_i = 64'h1122_3344_5566_7788;
    tick();
    beat_i = 1'b0; wen_i = 1'b0;
    do_start(32'h40, 8'd0, 3'd3, 2'b01);
    chk("bm_last_len0", 64'(last_o), 64'd1);
    beat_i = 1'b1;
    tick();
    beat_i = 1'b0;
    chk("bm_rdata", rdata_o, 64'hFFFF_FFFF_5566_7788);
    chk("bm_busy", 64'(busy_o), 64'd0);

    // Page wrap.
    do_start(32'h1FF8, 8'd1, 3'd3, 2'b01);
    beat_i = 1'b1; wen_i = 1'b0;
    chk("pg_addr0", 64'(addr_o), 64'h1FF8);
    tick();
    chk("pg_addr1", 64'(addr_o), 64'h1000);
    chk("pg_last1", 64'(last_o), 64'd1);
    tick();
    beat_i = 1'b0;

    // Narrow INCR, size 2; oversize size (7) clamps to 3.
    do_start(32'h4, 8'd1, 3'd2, 2'b01);
    beat_i = 1'b1;
    chk("nar_addr0", 64'(addr_o), 64'h4);
    tick();
    chk("nar_data0", rdata_o, pat(0));
    chk("nar_addr1", 64'(addr_o), 64'h8);
    tick();
    chk("nar_data1", rdata_o, pat(1));
    beat_i = 1'b0;
    do_start(32'h8, 8'd1, 3'd7, 2'b01);
    beat_i = 1'b1;
    tick();
    chk("clamp_addr1", 64'(addr_o), 64'h10);
    beat_i = 1'b0;

    // Restart with coincident beat: write dropped, new burst loaded.
    do_start(32'h8, 8'd3, 3'd3, 2'b01);
    start_i = 1'b1; beat_i = 1'b1; wen_i = 1'b1; wstrb_i = 8'hFF;
    wdata_i = 64'hDEAD_BEEF_DEAD_BEEF; addr_i = 32'h0; len_i = 8'd0;
    tick();
    start_i = 1'b0; beat_i = 1'b0; wen_i = 1'b0;
    chk("rs_addr", 64'(addr_o), 64'h0);
    chk("rs_last", 64'(last_o), 64'd1);
    // Beat while idle is ignored.
    beat_i = 1'b1;
    tick();
    beat_i = 1'b0; wen_i = 1'b1;
    beat_i = 1'b1;
    tick();
    beat_i = 1'b0; wen_i = 1'b0;
    chk("idle_beat_busy", 64'(busy_o), 64'd0);

    // Reset mid-burst.
    do_start(32'h0, 8'd3, 3'd3, 2'b01);
    beat_i = 1'b1;
    tick();
    chk("mr_rvalid_pre", 64'(rvalid_o), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("mr_busy", 64'(busy_o), 64'd0);
    chk("mr_addr", 64'(addr_o), 64'd0);
    chk("mr_rvalid", 64'(rvalid_o), 64'd0);
    beat_i = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    do_start(32'h0, 8'd3, 3'd3, 2'b01);
    for (int k = 0; k < 4; k++) begin
      beat_i = 1'b1;
      tick();
      chk($sformatf("mr_data%0d", k), rdata_o, pat(k));
    end
    beat_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_regfile.md
# burst_regfile

Single-port, byte-masked register-file memory with a built-in AXI4-style burst address generator. The block accepts a burst descriptor (address, length, size, burst type), then performs one read or write per beat. After each beat it steps the address using AXI4 FIXED/INCR/WRAP rules inside a 4 KB page. It is the storage and addressing core beneath an AXI4 slave SRAM front end; the protocol FSM above it only issues start/beat strobes.

## Interface
- DATA_WIDTH, 64: word width in bits; the byte count DATA_WIDTH/8 is a power of two.
- WORD_DEPTH, 512: words of storage; a power of two.
- ADDR_WIDTH, 32: byte address width.
- OFT_WIDTH, 12: page offset width. Bursts never leave a 2^OFT_WIDTH-byte page.
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- start_i  in  1  load a burst descriptor; sets busy.
- addr_i  in  ADDR_WIDTH  burst start byte address.
- len_i  in  8  beats minus one.
- size_i  in  3  log2 of bytes per beat.
- burst_i  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- beat_i  in  1  perform one access at addr_o, then advance.
- wen_i  in  1  the beat is a write (1) or a read (0).
- wstrb_i  in  DATA_WIDTH/8  byte write enables.
- wdata_i  in  DATA_WIDTH  write data.
- rdata_o  out  DATA_WIDTH  registered read data.
- rvalid_o  out  1  rdata_o was updated by the previous cycle's read beat.
- addr_o  out  ADDR_WIDTH  current beat address.
- last_o  out  1  the current beat is the final beat (beat count == len).
- busy_o  out  1  a burst is active.

## Operation
- Reset values: busy_o=0, addr_o=0, last_o=0, rvalid_o=0, rdata_o=0, beat counter=0, stored len/size/burst=0. Memory contents are not reset.
- Storage addressing:
  - Word index = addr_o[log2(DATA_WIDTH/8) +: log2(WORD_DEPTH)].
  - Higher address bits are ignored, so addresses alias.
  - Internal array controls are active-low (en_n, wen_n, bm_n), driven as the inversion of the beat strobes.
- Write beat (beat_i & busy_o & wen_i): each byte with its wstrb_i bit set is written at the word index; the other bytes are unchanged.
- Read beat (beat_i & busy_o & !wen_i): rdata_o is loaded on the next edge and rvalid_o is high for exactly that cycle. Otherwise rdata_o holds its value.
- After every beat: the counter increments and addr_o takes the next address. If last_o was high, busy_o clears and the counter returns to 0.
- Size clamp: size_i larger than log2(DATA_WIDTH/8) is treated as log2(DATA_WIDTH/8). Bytes per beat is B = 1<<size.
- Next address is computed on the low OFT_WIDTH bits; the upper bits are held:
  - FIXED: unchanged.
  - INCR: (addr & ~(B-1)) + B, modulo 2^OFT_WIDTH.
  - WRAP: with W = (len+1)*B, next = (addr & ~(W-1)) | ((addr+B) & (W-1)). This applies only when len is 1, 3, 7 or 15; any other len is handled as INCR.
  - Reserved type 11: handled as FIXED.
- Ignored and priority cases:
  - beat_i while idle is ignored.
  - start_i while busy restarts the burst.
  - When start_i and beat_i are high together, start wins and the beat is dropped (no memory access).

## Timing
- start_i at edge N: from N+1, addr_o = addr_i, busy_o = 1, and last_o = (len_i == 0).
- A write is committed at the edge that samples beat_i.
- Read latency is one cycle: rdata_o and rvalid_o are valid in the cycle after the beat.
- One beat is allowed per cycle, so back-to-back beats sustain full throughput.
- last_o and addr_o are combinational from registered state only.
- Reset asserted mid-burst forces all reset values immediately; stored memory words are retained.

## Configuration
- SRAM_WRAP_EN defined: WRAP bursts follow the wrap rule above.
- SRAM_WRAP_EN undefined: the WRAP logic is removed and burst 10 is handled as INCR.

## Test plan
- INCR read:
  - Stimulus: write words 0–3 with 0x0…0, 0x1…1, 0x2…2, 0x3…3. Then start addr 0x0, len 3, size 3, INCR, and issue 4 read beats.
  - Required: addr_o steps 0x0, 0x8, 0x10, 0x18; rdata_o returns the four patterns, each one cycle after its beat; last_o is high on the 4th beat; busy_o drops after it.
- WRAP (with SRAM_WRAP_EN): start addr 0x18, len 3, size 3 -> addr_o steps 0x18, 0x0, 0x8, 0x10.
- FIXED: start addr 0x20, len 2 -> addr_o stays 0x20 for 3 beats and last_o is high only on the third.
- Byte mask:
  - Stimulus: write 0xFFFF_FFFF_FFFF_FFFF with wstrb 0xFF, then write 0x1122_3344_5566_7788 with wstrb 0x0F, then read.
  - Required: rdata_o = 0xFFFF_FFFF_5566_7788.
- Page wrap and narrow size:
  - INCR from 0x1FF8, len 1, size 3 -> 0x1FF8 then 0x1000.
  - INCR from 0x4, size 2 -> 0x4 then 0x8, both mapping to word index 0 then 1.
- Reset mid-burst: assert aresetn=0 during beat 2 -> busy_o, addr_o and rvalid_o are 0 at once; a later read of the previously written words returns the same data.
